seq_stim_gen: RTL and testbench
===============================

Name: seq_stim_gen

Overview:
Hardware stimulus generator and response compactor for the lab's two-input, two-output sequential circuits (inputs a/b, outputs y/z). It plays back a programmed table of (a, b, hold) steps into the circuit under test and compresses the returned y/z stream into a 16-bit signature. This lets a sequence be run and checked on the board without a simulator testbench. It sits between the board control logic (switches, UART, or a host register block) and the sequential circuit under test.

Parameters:
DEPTH, 16, number of pattern entries
AW, 4, address width, log2(DEPTH)
HW, 8, width of the hold-cycle field per entry

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-low
wr_en  in  1  write one pattern entry this cycle
wr_addr  in  AW  entry index
wr_data  in  HW+2  entry contents {a, b, hold[HW-1:0]}
len  in  AW+1  number of entries to play; latched when start is accepted
start  in  1  begin playback (level-sampled in IDLE)
loop_en  in  1  repeat the table instead of finishing; sampled at each wrap
abort  in  1  stop playback
y  in  1  response from the circuit under test
z  in  1  response from the circuit under test
a  out  1  stimulus to the circuit under test (registered)
b  out  1  stimulus to the circuit under test (registered)
busy  out  1  high while in RUN
done  out  1  one-cycle pulse at normal completion
step  out  AW  index of the entry currently being driven
sig  out  16  response signature (MISR)

Behaviour:
- Reset (rst=0), asynchronous: state=IDLE; a=b=busy=done=0; step=0; sig=0; hold counter=0. Pattern memory is not reset.
- States are IDLE, RUN and DONE.
- IDLE to RUN:
  - Transition occurs when start=1, abort=0 and len!=0.
  - The latched length is min(len, DEPTH).
  - On the next cycle: busy=1, step=0, {a,b}=mem[0].{a,b}, and the hold counter is loaded.
  - start with len=0 is ignored.
- Hold rule: each entry drives a/b for max(hold,1) consecutive cycles; hold=0 behaves as 1.
- At the last cycle of an entry:
  - If step < len-1: step increments and the next entry loads with no gap cycle.
  - If step = len-1 and loop_en=1: step wraps to 0, mem[0] loads, no done pulse.
  - If step = len-1 and loop_en=0: go to DONE.
- DONE lasts exactly one cycle: done=1, busy=0, a=b=0, step holds its last value; then IDLE.
- abort in RUN: on the next cycle state=IDLE, a=b=0, busy=0, no done pulse, sig frozen.
- abort has priority over start in the same cycle.
- start while busy is ignored.
- Memory writes:
  - Accepted in any state.
  - An entry is read when it is loaded, so an in-run write affects the next load of that entry.
  - A write and a load of the same address in the same cycle: the load sees the old data.
- MISR:
  - Cleared to 0 on the cycle start is accepted.
  - Updates on every cycle busy=1, including the first RUN cycle: sig <= {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ {14'b0, y, z}.
  - Holds its value in IDLE and DONE.
  - Is readable after done.
- Mid-run reset: all outputs return to reset values immediately; the latched len is cleared.

Decomposition:
- Shared package/include holds:
  - state encodings (IDLE, RUN, DONE)
  - MISR_POLY = 16'h1021
  - entry field positions (A_BIT = HW+1, B_BIT = HW, hold = [HW-1:0])
- One natural sub-module: stim_misr16 (clk, rst, clr, en, y, z, sig), reusable by other lab checkers.

Test Plan:
1. Assert rst low during RUN at an arbitrary point (not on a clock edge) -> a, b, busy, done, step and sig all read 0 immediately.
2. Load {(0,1,2),(1,1,3),(1,0,1)}, len=3, loop_en=0, pulse start -> busy rises next cycle; {a,b} = 01,01,11,11,11,10 over 6 cycles; then done=1 for one cycle with a=b=0; then IDLE.
3. Same program with loop_en=1 -> the 6-cycle pattern repeats, step goes 2 to 0 with no done; abort mid-entry -> next cycle busy=0, a=b=0, done stays 0.
4. Entry with hold=0 -> driven for exactly 1 cycle; start with len=0 -> stays IDLE; len=20 -> plays 16 entries then done.
5. Signature check: y=z=0 for the whole run -> sig=0x0000. Hold y=1, z=0 for the first 2 RUN cycles -> sig=0x0002, then 0x0006.
6. start and abort together in IDLE -> stays IDLE. start pulsed during RUN -> no restart, step unaffected. Write to entry 1 while entry 0 plays -> new entry-1 value is driven.

Source files
------------

// File: rtl/seq_stim_gen_pkg.sv
// Shared definitions for the sequential stimulus generator and its response compactor.
// Entry layout is {a, b, hold[HW-1:0]}.
package seq_stim_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] MISR_POLY = 16'h1021;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_AW    = 4;
  localparam int DEF_HW    = 8;

  localparam int A_BIT = DEF_HW + 1;
  localparam int B_BIT = DEF_HW;

endpackage

// File: rtl/stim_misr16.sv
// 16-bit MISR folding a two-bit response (y, z) into a signature each enabled cycle.
// Reusable by other lab checkers; clr wins over en.
module stim_misr16
  import seq_stim_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        y,
  input  logic        z,
  output logic [15:0] sig
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ {14'b0, y, z};
    end
  end

endmodule

// File: rtl/seq_stim_gen.sv
// Plays a programmed table of (a, b, hold) entries into a circuit under test and
// compacts its y/z response into a 16-bit signature.
module seq_stim_gen
  import seq_stim_gen_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int HW    = DEF_HW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [HW+1:0] wr_data,
  input  logic [AW:0]   len,
  input  logic          start,
  input  logic          loop_en,
  input  logic          abort,
  input  logic          y,
  input  logic          z,
  output logic          a,
  output logic          b,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] step,
  output logic [15:0]   sig
);

  localparam int ABIT = HW + 1;
  localparam int BBIT = HW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [HW+1:0] mem [DEPTH];
  state_t        state, state_nxt;
  logic [AW:0]   len_q;
  logic [HW-1:0] cnt;
  logic          accept, entry_end, last_entry, load;
  logic [AW-1:0] load_idx;
  logic [HW+1:0] load_entry;

  // Memory is deliberately left unreset; a same-cycle load reads the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign accept     = (state == IDLE) && start && !abort && (len != '0);
  assign entry_end  = (cnt == '0);
  assign last_entry = ({1'b0, step} == (len_q - (AW+1)'(1)));
  assign load_entry = mem[load_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        if (abort)                                     state_nxt = IDLE;
        else if (entry_end && last_entry && !loop_en)  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Decide whether an entry is fetched this cycle and which one.
  always_comb begin
    load     = 1'b0;
    load_idx = '0;
    if (accept) begin
      load = 1'b1;
    end else if ((state == RUN) && !abort && entry_end) begin
      if (!last_entry) begin
        load     = 1'b1;
        load_idx = step + AW'(1);
      end else if (loop_en) begin
        load = 1'b1;
      end
    end
  end

  // cnt holds the cycles remaining after the current one, so hold=0 and hold=1 both give one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a     <= 1'b0;
      b     <= 1'b0;
      step  <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else begin
      if (accept) len_q <= (len > DEPTH_L) ? DEPTH_L : len;
      if (load) begin
        a    <= load_entry[ABIT];
        b    <= load_entry[BBIT];
        step <= load_idx;
        cnt  <= (load_entry[HW-1:0] == '0) ? '0 : load_entry[HW-1:0] - HW'(1);
      end else if (state == RUN) begin
        if (abort || entry_end) begin
          a <= 1'b0;
          b <= 1'b0;
        end else begin
          cnt <= cnt - HW'(1);
        end
      end
    end
  end

  stim_misr16 u_misr (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (busy),
    .y   (y),
    .z   (z),
    .sig (sig)
  );

endmodule

// File: tb/tb_seq_stim_gen.sv
// Self-checking bench for seq_stim_gen: directed scenarios plus randomized programs,
// compared against an expanded cycle-by-cycle expectation built from the entry table.
module tb_seq_stim_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [9:0]  wr_data;
  logic [4:0]  len;
  logic        start, loop_en, abort, y, z;
  logic        a, b, busy, done;
  logic [3:0]  step;
  logic [15:0] sig;

  int nAsserts = 0;
  int nFails   = 0;

  logic progA [16];
  logic progB [16];
  int   progH [16];

  seq_stim_gen dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .len     (len),
    .start   (start),
    .loop_en (loop_en),
    .abort   (abort),
    .y       (y),
    .z       (z),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .step    (step),
    .sig     (sig)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Signature polynomial arithmetic: multiply by x modulo x^16+x^12+x^5+1, add response.
  function automatic logic [15:0] misrStep(input logic [15:0] s, input logic yi, input logic zi);
    logic [16:0] t;
    t = {s, 1'b0};
    if (t[16]) t[15:0] = t[15:0] ^ 16'h1021;
    return t[15:0] ^ {14'd0, yi, zi};
  endfunction

  task automatic randomProgram(input int maxHold);
    for (int i = 0; i < 16; i++) begin
      progA[i] = 1'($urandom);
      progB[i] = 1'($urandom);
      progH[i] = $urandom_range(0, maxHold);
    end
  endtask

  // yzMode: 0 random, 1 all zero, 2 y=1/z=0 for the first two RUN cycles then zero.
  task automatic applyStimulus(input int lenIn, input bit loopEn, input int runCycles,
                               input int yzMode, input bit midStart, input bit midWrite);
    int          eff, total, nCycles, idx, reps;
    int          qa[$], qb[$], qs[$];
    logic [15:0] msig;
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_addr = 4'(i);
      wr_data = {progA[i], progB[i], 8'(progH[i])};
      tick();
    end
    wr_en = 1'b0;
    if (midWrite) begin
      progA[1] = ~progA[1];
      progB[1] = ~progB[1];
    end
    eff = (lenIn > 16) ? 16 : lenIn;
    for (int e = 0; e < eff; e++) begin
      reps = (progH[e] == 0) ? 1 : progH[e];
      for (int k = 0; k < reps; k++) begin
        qa.push_back(int'(progA[e]));
        qb.push_back(int'(progB[e]));
        qs.push_back(e);
      end
    end
    total   = qa.size();
    nCycles = loopEn ? runCycles : total;
    len     = 5'(lenIn);
    loop_en = loopEn;
    start   = 1'b1;
    tick();
    start = 1'b0;
    msig  = 16'h0000;
    for (int c = 0; c < nCycles; c++) begin
      idx = c % total;
      checkOutput("run_busy", 32'(busy), 32'd1);
      checkOutput("run_done", 32'(done), 32'd0);
      checkOutput("run_a",    32'(a),    32'(qa[idx]));
      checkOutput("run_b",    32'(b),    32'(qb[idx]));
      checkOutput("run_step", 32'(step), 32'(qs[idx]));
      checkOutput("run_sig",  32'(sig),  32'(msig));
      if (yzMode == 2 && c == 1) checkOutput("sig_after1", 32'(sig), 32'h0002);
      if (yzMode == 2 && c == 2) checkOutput("sig_after2", 32'(sig), 32'h0006);
      if (midWrite && c == 0) begin
        wr_en   = 1'b1;
        wr_addr = 4'd1;
        wr_data = {progA[1], progB[1], 8'(progH[1])};
      end
      if (midStart && c == 1) begin
        start = 1'b1;
        len   = 5'd1;
      end
      if (loopEn && c == nCycles - 1) abort = 1'b1;
      case (yzMode)
        0:       begin y = 1'($urandom); z = 1'($urandom); end
        1:       begin y = 1'b0; z = 1'b0; end
        default: begin y = (c < 2); z = 1'b0; end
      endcase
      tick();
      wr_en = 1'b0;
      start = 1'b0;
      msig  = misrStep(msig, y, z);
    end
    y = 1'b0;
    z = 1'b0;
    if (loopEn) begin
      abort = 1'b0;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_a",    32'(a),    32'd0);
      checkOutput("abort_b",    32'(b),    32'd0);
      checkOutput("abort_sig",  32'(sig),  32'(msig));
    end else begin
      checkOutput("done_pulse", 32'(done), 32'd1);
      checkOutput("done_busy",  32'(busy), 32'd0);
      checkOutput("done_a",     32'(a),    32'd0);
      checkOutput("done_b",     32'(b),    32'd0);
      checkOutput("done_step",  32'(step), 32'(eff - 1));
      checkOutput("done_sig",   32'(sig),  32'(msig));
    end
    tick();
    checkOutput("idle_done", 32'(done), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_sig",  32'(sig),  32'(msig));
    if (yzMode == 1) checkOutput("sig_zero", 32'(sig), 32'h0000);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; len = '0;
    start = 1'b0; loop_en = 1'b0; abort = 1'b0; y = 1'b0; z = 1'b0;
    #12;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_a",    32'(a),    32'd0);
    checkOutput("rst_step", 32'(step), 32'd0);
    checkOutput("rst_sig",  32'(sig),  32'd0);
    rst = 1'b1;
    tick();

    $display("[TB] basic three-entry program");
    randomProgram(3);
    progA[0] = 1'b0; progB[0] = 1'b1; progH[0] = 2;
    progA[1] = 1'b1; progB[1] = 1'b1; progH[1] = 3;
    progA[2] = 1'b1; progB[2] = 1'b0; progH[2] = 1;
    applyStimulus(3, 1'b0, 0, 0, 1'b0, 1'b0);

    $display("[TB] looping program with abort mid-entry");
    applyStimulus(3, 1'b1, 9, 0, 1'b0, 1'b0);

    $display("[TB] signature checks");
    applyStimulus(3, 1'b0, 0, 1, 1'b0, 1'b0);
    applyStimulus(3, 1'b0, 0, 2, 1'b0, 1'b0);

    $display("[TB] hold zero and oversize length");
    progA[0] = 1'b1; progB[0] = 1'b0; progH[0] = 0;
    progA[1] = 1'b0; progB[1] = 1'b1; progH[1] = 2;
    applyStimulus(2, 1'b0, 0, 0, 1'b0, 1'b0);
    randomProgram(2);
    applyStimulus(20, 1'b0, 0, 0, 1'b0, 1'b0);

    $display("[TB] ignored starts");
    len = 5'd0; start = 1'b1;
    tick();
    checkOutput("len0_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("len0_busy2", 32'(busy), 32'd0);
    len = 5'd3; abort = 1'b1;
    tick();
    checkOutput("start_abort_busy", 32'(busy), 32'd0);
    start = 1'b0; abort = 1'b0;
    tick();
    checkOutput("start_abort_idle", 32'(busy), 32'd0);

    $display("[TB] start during run and in-run write");
    randomProgram(3);
    progH[0] = 3;
    applyStimulus(4, 1'b0, 0, 0, 1'b1, 1'b0);
    applyStimulus(3, 1'b0, 0, 0, 1'b0, 1'b1);

    $display("[TB] asynchronous reset during run");
    randomProgram(3);
    progH[0] = 3;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = {progA[i], progB[i], 8'(progH[i])};
      tick();
    end
    wr_en = 1'b0;
    len = 5'd8; start = 1'b1; y = 1'b1; z = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #3;
    rst = 1'b0;
    #1;
    checkOutput("mrst_a",    32'(a),    32'd0);
    checkOutput("mrst_b",    32'(b),    32'd0);
    checkOutput("mrst_busy", 32'(busy), 32'd0);
    checkOutput("mrst_done", 32'(done), 32'd0);
    checkOutput("mrst_step", 32'(step), 32'd0);
    checkOutput("mrst_sig",  32'(sig),  32'd0);
    #2;
    rst = 1'b1; y = 1'b0; z = 1'b0;
    tick();
    checkOutput("mrst_idle", 32'(busy), 32'd0);

    $display("[TB] randomized programs");
    for (int r = 0; r < 14; r++) begin
      randomProgram(3);
      applyStimulus($urandom_range(1, 20), 1'b0, 0, 0, 1'($urandom), 1'b0);
    end
    for (int r = 0; r < 3; r++) begin
      randomProgram(2);
      applyStimulus($urandom_range(1, 6), 1'b1, $urandom_range(5, 40), 0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
